// File: rtl/rv_imm_pkg.sv
// Shared definitions for the immediate packers and the instruction assembler.
package rv_imm_pkg;
  localparam int IMM21_W = 21;
  localparam int DATA_W  = 32;
  localparam int SHIFT_W = 2;

  typedef struct packed {
    logic [IMM21_W-1:0] imm;
    logic               ovf;
    logic               misalign;
  } imm_pack_res_t;
endpackage

// File: rtl/imm_fit_check.sv
// Combinational arithmetic right shift, signed-range check and alignment check.
// Parameterised so the 12-bit and 13-bit packers can share it.
module imm_fit_check #(
  parameter int IN_W    = 32,
  parameter int OUT_W   = 21,
  parameter int SHIFT_W = 2
) (
  input  logic [IN_W-1:0]    value_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [OUT_W-1:0]   imm_o,
  output logic               ovf_o,
  output logic               misalign_o
);
  logic [IN_W-1:0]    sh_s;
  logic [IN_W-OUT_W:0] hi_s;
  logic [IN_W-1:0]    mask_s;

  assign sh_s   = $signed(value_i) >>> shift_i;
  // Representable iff everything from the new sign bit upward is a copy of it.
  assign hi_s   = sh_s[IN_W-1:OUT_W-1];
  assign mask_s = ~({IN_W{1'b1}} << shift_i);

  assign imm_o      = sh_s[OUT_W-1:0];
  assign ovf_o      = ~((&hi_s) | ~(|hi_s));
  assign misalign_o = |(value_i & mask_s);
endmodule

// File: rtl/imm_pack_21.sv
// Two-stage valid/ready pipeline packing a 32-bit signed offset into a 21-bit
// immediate with overflow/misalignment flags and a saturating error counter.
module imm_pack_21
  import rv_imm_pkg::*;
#(
  parameter int IN_W  = DATA_W,
  parameter int OUT_W = IMM21_W,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_value,
  input  logic [SHIFT_W-1:0] in_shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_imm,
  output logic               out_ovf,
  output logic               out_misalign,
  output logic [CNT_W-1:0]   err_cnt,
  input  logic               err_clr
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic               s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]    s1_value_q, s1_value_d;
  logic [SHIFT_W-1:0] s1_shift_q, s1_shift_d;
  logic               s2_valid_q, s2_valid_d;
  imm_pack_res_t      s2_q, s2_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [OUT_W-1:0]   fit_imm_s;
  logic               fit_ovf_s;
  logic               fit_mis_s;
  logic               s2_adv_s, s1_adv_s, accept_s;

  imm_fit_check #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .SHIFT_W(SHIFT_W)
  ) u_fit (
    .value_i   (s1_value_q),
    .shift_i   (s1_shift_q),
    .imm_o     (fit_imm_s),
    .ovf_o     (fit_ovf_s),
    .misalign_o(fit_mis_s)
  );

  assign s2_adv_s = ~s2_valid_q | out_ready;
  assign s1_adv_s = s1_valid_q & s2_adv_s;
  assign in_ready = ~s1_valid_q | s2_adv_s;
  assign accept_s = in_valid & in_ready;

  // Next-state for both pipeline stages and the error counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_value_d = s1_value_q;
    s1_shift_d = s1_shift_q;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    err_cnt_d  = err_cnt_q;

    if (accept_s) begin
      s1_valid_d = 1'b1;
      s1_value_d = in_value;
      s1_shift_d = in_shift;
    end else if (s1_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s1_adv_s) begin
      s2_valid_d    = 1'b1;
      s2_d.imm      = fit_imm_s;
      s2_d.ovf      = fit_ovf_s;
      s2_d.misalign = fit_mis_s;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end

    // Clear wins over a same-cycle erroring advance.
    if (err_clr) begin
      err_cnt_d = {CNT_W{1'b0}};
    end else if (s1_adv_s && (fit_ovf_s || fit_mis_s) && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_ONE;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_value_q <= {IN_W{1'b0}};
      s1_shift_q <= {SHIFT_W{1'b0}};
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
      err_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_value_q <= s1_value_d;
      s1_shift_q <= s1_shift_d;
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_imm      = s2_q.imm;
  assign out_ovf      = s2_q.ovf;
  assign out_misalign = s2_q.misalign;
  assign err_cnt      = err_cnt_q;
endmodule

// File: tb/tb_imm_pack_21.sv
// Directed bench for imm_pack_21 with hand-computed expectations.
module tb_imm_pack_21;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic [1:0]  in_shift;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] out_imm;
  logic        out_ovf;
  logic        out_misalign;
  logic [7:0]  err_cnt;
  logic        err_clr;

  int vectors = 0;
  int miscompares = 0;

  imm_pack_21 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_value    (in_value),
    .in_shift    (in_shift),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_ovf     (out_ovf),
    .out_misalign(out_misalign),
    .err_cnt     (err_cnt),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat with out_ready high; checks 2-cycle latency and result.
  task automatic send_check(input string tag, input logic [31:0] v, input logic [1:0] s,
                            input logic [20:0] ei, input logic eo, input logic em,
                            input logic [7:0] ec);
    in_value  = v;
    in_shift  = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
    step();
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_imm"}, {11'd0, out_imm}, {11'd0, ei});
    chk({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, eo});
    chk({tag, "_mis"}, {31'd0, out_misalign}, {31'd0, em});
    chk({tag, "_cnt"}, {24'd0, err_cnt}, {24'd0, ec});
    step();
    chk({tag, "_once"}, {31'd0, out_valid}, 32'd0);
  endtask

  logic [31:0] sv [8];
  logic [1:0]  ss [8];
  logic [20:0] se [8];

  initial begin
    int sent, got, occ;
    logic acc, xfer;

    sv[0] = 32'h00000011; ss[0] = 2'd0; se[0] = 21'h000011;
    sv[1] = 32'h00000022; ss[1] = 2'd0; se[1] = 21'h000022;
    sv[2] = 32'hFFFFFFF0; ss[2] = 2'd0; se[2] = 21'h1FFFF0;
    sv[3] = 32'h000ABCDE; ss[3] = 2'd0; se[3] = 21'h0ABCDE;
    sv[4] = 32'hFFF12345; ss[4] = 2'd0; se[4] = 21'h112345;
    sv[5] = 32'h00000400; ss[5] = 2'd2; se[5] = 21'h000100;
    sv[6] = 32'h00000008; ss[6] = 2'd3; se[6] = 21'h000001;
    sv[7] = 32'hFFFFFFFC; ss[7] = 2'd2; se[7] = 21'h1FFFFF;

    rst_n = 1'b1; in_valid = 1'b0; in_value = 32'd0; in_shift = 2'd0;
    out_ready = 1'b0; err_clr = 1'b0;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_imm", {11'd0, out_imm}, 32'd0);
    chk("rst_ovf", {31'd0, out_ovf}, 32'd0);
    chk("rst_mis", {31'd0, out_misalign}, 32'd0);
    chk("rst_cnt", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);

    send_check("pos",  32'h000FFFFC, 2'd2, 21'h03FFFF, 1'b0, 1'b0, 8'd0);
    send_check("neg",  32'hFFF00000, 2'd0, 21'h100000, 1'b0, 1'b0, 8'd0);
    send_check("ovf",  32'h00100000, 2'd0, 21'h100000, 1'b1, 1'b0, 8'd1);
    send_check("mis",  32'h00000006, 2'd2, 21'h000001, 1'b0, 1'b1, 8'd2);

    // Back-to-back stream with out_ready pattern 1,0,0,1.
    sent = 0; got = 0; occ = 0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_value = sv[sent];
        in_shift = ss[sent];
      end else begin
        in_value = 32'd0;
        in_shift = 2'd0;
      end
      #1;
      chk("stream_rdy", {31'd0, in_ready}, {31'd0, !(occ == 2 && !out_ready)});
      if (out_valid) begin
        chk("stream_imm", {11'd0, out_imm}, {11'd0, se[got]});
        chk("stream_flags", {30'd0, out_ovf, out_misalign}, 32'd0);
      end
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (acc) sent++;
      if (xfer) got++;
      occ = occ + int'(acc) - int'(xfer);
      step();
    end
    in_valid = 1'b0;
    chk("stream_count", got, 32'd8);
    chk("stream_cnt", {24'd0, err_cnt}, 32'd2);

    // Saturation: 256 overflowing beats at full rate.
    out_ready = 1'b1;
    in_value  = 32'h00100000;
    in_shift  = 2'd0;
    in_valid  = 1'b1;
    repeat (256) step();
    in_valid = 1'b0;
    repeat (3) step();
    chk("sat_cnt", {24'd0, err_cnt}, 32'h000000FF);

    // err_clr in the same cycle as an erroring advance.
    in_value = 32'h00100000; in_shift = 2'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    err_clr  = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_cnt", {24'd0, err_cnt}, 32'd0);
    chk("clr_ovf", {31'd0, out_ovf}, 32'd1);
    step();
    send_check("after_clr", 32'hFFFFFFFF, 2'd1, 21'h1FFFFF, 1'b0, 1'b1, 8'd1);

    // Fill both stages, then reset asynchronously mid-cycle.
    out_ready = 1'b0;
    in_value = 32'h00000100; in_shift = 2'd0; in_valid = 1'b1;
    step();
    in_value = 32'h00000200;
    chk("fill_rdy", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("full_rdy", {31'd0, in_ready}, 32'd0);
    chk("full_vld", {31'd0, out_valid}, 32'd1);
    chk("full_imm", {11'd0, out_imm}, 32'h00000100);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", {31'd0, out_valid}, 32'd0);
    chk("arst_cnt", {24'd0, err_cnt}, 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("no_stale", {31'd0, out_valid}, 32'd0);
    end
    send_check("post_rst", 32'h00000040, 2'd3, 21'h000008, 1'b0, 1'b0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/imm_pack_21.md
# imm_pack_21

Pipelined immediate packer: the inverse of the 21-bit sign extender. Takes a 32-bit signed value, for example a branch or jump byte offset computed by the assembler/loader path, and applies an optional alignment shift. It checks that the result is representable as a 21-bit two's-complement field and emits the packed 21-bit immediate with error flags. It sits between offset generation and instruction-word assembly, using valid/ready handshakes on both sides.

## Interface
- IN_W, default 32: input value width.
- OUT_W, default 21: packed immediate width.
- CNT_W, default 8: width of the saturating error counter.
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_value  input  IN_W  signed value to pack.
- in_shift  input  2  number of low bits dropped by arithmetic right shift (0..3).
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- out_imm  output  OUT_W  packed immediate, (in_value >>> in_shift)[OUT_W-1:0].
- out_ovf  output  1  shifted value not representable in OUT_W signed bits.
- out_misalign  output  1  in_value[in_shift-1:0] non-zero (always 0 when in_shift=0).
- err_cnt  output  CNT_W  saturating count of accepted beats with ovf or misalign set.
- err_clr  input  1  synchronous clear of err_cnt.

## Operation
- Stage 1 (S1) register captures in_value, in_shift on accept (in_valid && in_ready).
- S1 combinational: sh = in_value >>> in_shift (arithmetic); ovf = bits sh[IN_W-1:OUT_W-1] not all equal; misalign = OR of low in_shift bits of the input.
- Stage 2 (S2) registers out_imm = sh[OUT_W-1:0], out_ovf, out_misalign.
- On error, out_imm still carries the truncated bits and is not clamped. Consumers must gate on the flags.
- Round-trip invariant: when both flags are 0, sign_extend(out_imm) <<< in_shift == in_value.
- err_cnt increments when S1 advances into S2 with (ovf || misalign) and saturates at 2^CNT_W-1.
- err_clr has priority over an increment in the same cycle; err_cnt becomes 0.
- Beat order is preserved. No beat is dropped or duplicated under any out_ready pattern.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - S1/S2 valid to 0, so out_valid = 0.
  - out_imm = 0, out_ovf = 0, out_misalign = 0, err_cnt = 0.
  - in_ready is 1 one cycle after rst_n deasserts.
- Latency: a beat accepted in cycle N appears with out_valid=1 in cycle N+2 when out_ready is held high.
- Throughput: one beat per cycle with out_ready high.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_adv.
  - in_ready = !s1_valid || s2_adv. This is a combinational path from out_ready, which is permitted.
- Output holding: out_valid, once high, stays high with out_imm and the flags stable until out_ready is sampled high.
- Full pipeline: both stages valid and out_ready low gives in_ready = 0. An input held valid is not lost.
- Simultaneous events:
  - Accept and output transfer in the same cycle: both happen.
  - err_clr together with an erroring advance: count = 0.
- Reset mid-operation: in-flight beats are discarded. Nothing is emitted after reset until a new accept.

## Structure
- Shared package (rv_imm_pkg) holds:
  - IMM21_W = 21 and DATA_W = 32.
  - SHIFT_W = 2.
  - A packed struct imm_pack_res_t {imm, ovf, misalign} used for S2 and by the instruction assembler.
- One sub-module: imm_fit_check (combinational shift + representability + alignment check). It is reusable for the 12-bit and 13-bit immediate packers.
- Pipeline control and the error counter live in the top module.

## Test plan
- in_value=32'h000FFFFC, in_shift=2, out_ready=1:
  - out_imm=21'h03FFFF, ovf=0, misalign=0.
  - Appears 2 cycles after accept.
- in_value=32'hFFF00000, in_shift=0:
  - out_imm=21'h100000, ovf=0.
- in_value=32'h00100000, in_shift=0:
  - ovf=1, out_imm=21'h100000.
  - err_cnt goes 0→1.
- in_value=32'h00000006, in_shift=2:
  - misalign=1, out_imm=21'h000001.
  - err_cnt increments.
- Stream 8 values back-to-back while out_ready toggles 1,0,0,1,…:
  - All 8 emerge in order, each exactly once.
  - in_ready low only when both stages are full.
  - Outputs stable while stalled.
- 256 overflowing beats: err_cnt saturates at 8'hFF.
- err_clr asserted in the same cycle as an erroring advance: err_cnt = 0.
- rst_n pulsed low with 2 beats in flight: out_valid drops asynchronously and no stale beat appears afterward.
